memory_access_stage: RTL and testbench

MEMORY_ACCESS_STAGE -- requirements
Module: memory_access_stage

---
 rtl/memory_access_stage.sv | 225 ++++++++++++++++++++++
 tb/tb_memory_access_stage.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_access_stage.sv
// Memory access stage: issues one load/store per instruction to a 64-bit data
// memory, aligns store data and byte strobes, and extracts/extends load data.
// Build option: define MEM_TIMEOUT_EN to abort accesses that receive no
// dmem_ready within TIMEOUT_CYCLES BUSY cycles (reported via bus_error).
//
// Ports:
//   clk, reset                      rising-edge clock, synchronous active-high reset
//   valid_in, mem_read, mem_write   instruction from execute (store wins over load)
//   funct3, addr, wdata             access size/sign, effective address, store data
//   dmem_req/we/addr/wdata/wstrb    memory request (held until dmem_ready)
//   dmem_ready, dmem_rdata          memory completion and read doubleword
//   stall                           upstream hold (combinational)
//   valid_out, load_data            one-cycle result strobe and extended load value
//   misaligned, bus_error           qualifiers of valid_out
module memory_access_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255  // must be >= 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [63:0] dmem_addr,
    output logic [63:0] dmem_wdata,
    output logic [7:0]  dmem_wstrb,
    input  logic        dmem_ready,
    input  logic [63:0] dmem_rdata,
    output logic        stall,
    output logic        valid_out,
    output logic [63:0] load_data,
    output logic        misaligned,
    output logic        bus_error
);

    localparam int unsigned XLEN   = 64;
    localparam int unsigned STRB_W = XLEN / 8;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_e;

    state_e              state_q;
    logic                dmem_req_q;
    logic                dmem_we_q;
    logic [XLEN-1:0]     dmem_addr_q;
    logic [XLEN-1:0]     dmem_wdata_q;
    logic [STRB_W-1:0]   dmem_wstrb_q;
    logic                valid_out_q;
    logic                misaligned_q;
    logic [XLEN-1:0]     load_data_q;
    logic                is_load_q;
    logic [1:0]          size_q;
    logic                zext_q;
    logic [2:0]          off_q;

    logic                mem_op_c;
    logic                aligned_c;
    logic                accept_c;
    logic [STRB_W-1:0]   wstrb_d;
    logic [XLEN-1:0]     wdata_d;
    logic [XLEN-1:0]     rdata_shifted;
    logic [XLEN-1:0]     load_ext_d;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 2);
    logic [CNT_W-1:0]    tmo_cnt_q;
    logic                bus_error_q;
`endif

    // Natural alignment: address is a multiple of the access size.
    always_comb begin
        aligned_c = 1'b1;
        case (funct3[1:0])
            2'd0:    aligned_c = 1'b1;
            2'd1:    aligned_c = (addr[0] == 1'b0);
            2'd2:    aligned_c = (addr[1:0] == 2'b00);
            default: aligned_c = (addr[2:0] == 3'b000);
        endcase
    end

    assign mem_op_c = mem_read | mem_write;
    assign accept_c = (state_q == IDLE) & valid_in & mem_op_c & aligned_c;

    // Upstream must hold from the accept cycle until the memory responds.
    assign stall = ~reset & (accept_c | (state_q == BUSY));

    // Store lane placement: size mask and data moved to the addressed byte lane.
    always_comb begin
        wstrb_d = STRB_W'(8'h01);
        case (funct3[1:0])
            2'd0:    wstrb_d = STRB_W'(8'h01);
            2'd1:    wstrb_d = STRB_W'(8'h03);
            2'd2:    wstrb_d = STRB_W'(8'h0F);
            default: wstrb_d = STRB_W'(8'hFF);
        endcase
        wstrb_d = wstrb_d << addr[2:0];
        wdata_d = wdata << {addr[2:0], 3'b000};
    end

    // Load extraction from the captured byte offset; LD has nothing to extend.
    always_comb begin
        rdata_shifted = dmem_rdata >> {off_q, 3'b000};
        load_ext_d    = rdata_shifted;
        case (size_q)
            2'd0: load_ext_d = zext_q ? {56'b0, rdata_shifted[7:0]}
                                      : {{56{rdata_shifted[7]}}, rdata_shifted[7:0]};
            2'd1: load_ext_d = zext_q ? {48'b0, rdata_shifted[15:0]}
                                      : {{48{rdata_shifted[15]}}, rdata_shifted[15:0]};
            2'd2: load_ext_d = zext_q ? {32'b0, rdata_shifted[31:0]}
                                      : {{32{rdata_shifted[31]}}, rdata_shifted[31:0]};
            default: load_ext_d = rdata_shifted;
        endcase
    end

    // Control FSM with registered memory-side and writeback-side outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            dmem_wstrb_q <= '0;
            valid_out_q  <= 1'b0;
            misaligned_q <= 1'b0;
            load_data_q  <= '0;
            is_load_q    <= 1'b0;
            size_q       <= 2'b00;
            zext_q       <= 1'b0;
            off_q        <= 3'b000;
`ifdef MEM_TIMEOUT_EN
            tmo_cnt_q    <= '0;
            bus_error_q  <= 1'b0;
`endif
        end else begin
            // Result qualifiers are single-cycle pulses.
            valid_out_q  <= 1'b0;
            misaligned_q <= 1'b0;
            load_data_q  <= '0;
`ifdef MEM_TIMEOUT_EN
            bus_error_q  <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (valid_in) begin
                        if (!mem_op_c) begin
                            valid_out_q <= 1'b1;
                        end else if (!aligned_c) begin
                            valid_out_q  <= 1'b1;
                            misaligned_q <= 1'b1;
                        end else begin
                            state_q      <= BUSY;
                            dmem_req_q   <= 1'b1;
                            dmem_we_q    <= mem_write;
                            dmem_addr_q  <= {addr[63:3], 3'b000};
                            dmem_wdata_q <= mem_write ? wdata_d : '0;
                            dmem_wstrb_q <= mem_write ? wstrb_d : '0;
                            is_load_q    <= ~mem_write;
                            size_q       <= funct3[1:0];
                            zext_q       <= funct3[2];
                            off_q        <= addr[2:0];
`ifdef MEM_TIMEOUT_EN
                            tmo_cnt_q    <= '0;
`endif
                        end
                    end
                end
                BUSY: begin
                    if (dmem_ready) begin
                        state_q      <= RESP;
                        dmem_req_q   <= 1'b0;
                        dmem_we_q    <= 1'b0;
                        dmem_wstrb_q <= '0;
                        valid_out_q  <= 1'b1;
                        load_data_q  <= is_load_q ? load_ext_d : '0;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state_q      <= RESP;
                        dmem_req_q   <= 1'b0;
                        dmem_we_q    <= 1'b0;
                        dmem_wstrb_q <= '0;
                        valid_out_q  <= 1'b1;
                        bus_error_q  <= 1'b1;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
                    end
`endif
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wdata = dmem_wdata_q;
    assign dmem_wstrb = dmem_wstrb_q;
    assign valid_out  = valid_out_q;
    assign misaligned = misaligned_q;
    assign load_data  = load_data_q;

`ifdef MEM_TIMEOUT_EN
    assign bus_error = bus_error_q;
`else
    // Without the timeout counter the parameter has no effect.
    logic timeout_unused;
    assign timeout_unused = ^TIMEOUT_CYCLES;
    assign bus_error      = 1'b0;
`endif

endmodule

// File: tb/tb_memory_access_stage.sv
// Testbench for memory_access_stage: per-cycle expected timeline built from
// the latency rules plus a byte-wise load/store model, with literal pins.
module tb_memory_access_stage;

    localparam int unsigned TO   = 4;
    localparam int          MAXC = 512;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in, mem_read, mem_write;
    logic [2:0]  funct3;
    logic [63:0] addr, wdata;
    logic        dmem_req, dmem_we;
    logic [63:0] dmem_addr, dmem_wdata;
    logic [7:0]  dmem_wstrb;
    logic        dmem_ready;
    logic [63:0] dmem_rdata;
    logic        stall, valid_out, misaligned, bus_error;
    logic [63:0] load_data;

    memory_access_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .mem_read(mem_read),
        .mem_write(mem_write), .funct3(funct3), .addr(addr), .wdata(wdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_ready(dmem_ready),
        .dmem_rdata(dmem_rdata), .stall(stall), .valid_out(valid_out),
        .load_data(load_data), .misaligned(misaligned), .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    // Expected per-cycle timeline (bit arrays default to 0 = idle outputs).
    bit        exp_req   [MAXC];
    bit        exp_stall [MAXC];
    bit        exp_vout  [MAXC];
    bit        exp_mis   [MAXC];
    bit        exp_berr  [MAXC];
    bit        exp_we    [MAXC];
    bit [63:0] exp_ld    [MAXC];
    bit [63:0] exp_addr  [MAXC];
    bit [63:0] exp_wdata [MAXC];
    bit [7:0]  exp_wstrb [MAXC];

    // Observations recorded by the compare process.
    int          req_total  = 0;
    int          vout_total = 0;
    int          last_vout_cyc = 0;
    logic [63:0] last_ld, last_addr, last_wdata;
    logic [7:0]  last_wstrb;
    logic        last_we, last_mis, last_berr;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    // Byte-wise load result: gather the addressed bytes, then extend.
    function automatic logic [63:0] model_load(input logic [2:0] f3, input logic [63:0] a,
                                               input logic [63:0] rd);
        int nb;
        int off;
        logic [63:0] v;
        nb  = 1 << f3[1:0];
        off = int'(a[2:0]);
        v   = '0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = rd[8*(off+i) +: 8];
        if (!f3[2] && nb < 8 && v[8*nb-1])
            for (int i = nb; i < 8; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    function automatic logic [7:0] model_strb(input logic [2:0] f3, input logic [63:0] a);
        logic [7:0] s;
        int nb;
        nb = 1 << f3[1:0];
        s  = '0;
        for (int i = 0; i < nb; i++) s[int'(a[2:0]) + i] = 1'b1;
        return s;
    endfunction

    // Compare process: every cycle after the first edge.
    always @(negedge clk) begin
        if (cyc >= 1 && cyc < MAXC) begin
            check("dmem_req", 64'(dmem_req), 64'(exp_req[cyc]));
            if (!reset) check("stall", 64'(stall), 64'(exp_stall[cyc]));
            check("valid_out", 64'(valid_out), 64'(exp_vout[cyc]));
            check("misaligned", 64'(misaligned), 64'(exp_mis[cyc]));
            check("bus_error", 64'(bus_error), 64'(exp_berr[cyc]));
            if (exp_vout[cyc]) check("load_data", load_data, exp_ld[cyc]);
            if (exp_req[cyc]) begin
                check("dmem_we", 64'(dmem_we), 64'(exp_we[cyc]));
                check("dmem_addr", dmem_addr, exp_addr[cyc]);
                check("dmem_wstrb", 64'(dmem_wstrb), 64'(exp_wstrb[cyc]));
                if (exp_we[cyc]) check("dmem_wdata", dmem_wdata, exp_wdata[cyc]);
            end
            if (dmem_req) begin
                req_total++;
                last_addr  = dmem_addr;
                last_wdata = dmem_wdata;
                last_wstrb = dmem_wstrb;
                last_we    = dmem_we;
            end
            if (valid_out) begin
                vout_total++;
                last_vout_cyc = cyc;
                last_ld   = load_data;
                last_mis  = misaligned;
                last_berr = bus_error;
            end
        end
    end

    // One instruction; delay = BUSY cycle in which dmem_ready rises (0 = never).
    task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [63:0] a, input logic [63:0] wd,
                          input logic [63:0] rdat, input int delay, output int t_acc);
        int T, nb, off, busy;
        logic is_mem, algn, tmo;
        T = cyc;
        t_acc = T;
        nb = 1 << f3[1:0];
        off = int'(a[2:0]);
        is_mem = rd | wr;
        algn = (off % nb) == 0;
        valid_in = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3;
        addr = a; wdata = wd; dmem_ready = 1'b0; dmem_rdata = ~rdat;
        if (!is_mem || !algn) begin
            exp_vout[T+1] = 1'b1;
            exp_mis[T+1]  = is_mem;
            exp_ld[T+1]   = '0;
            @(posedge clk); #1;
            valid_in = 1'b0;
            @(posedge clk); #1;
        end else begin
            tmo  = 1'b0;
            busy = delay;
`ifdef MEM_TIMEOUT_EN
            if (delay == 0 || delay > int'(TO)) begin
                tmo  = 1'b1;
                busy = int'(TO);
            end
`endif
            exp_stall[T] = 1'b1;
            for (int k = 1; k <= busy; k++) begin
                exp_stall[T+k] = 1'b1;
                exp_req[T+k]   = 1'b1;
                exp_we[T+k]    = wr;
                exp_addr[T+k]  = {a[63:3], 3'b000};
                exp_wdata[T+k] = wd << (8*off);
                exp_wstrb[T+k] = wr ? model_strb(f3, a) : 8'h00;
            end
            exp_vout[T+busy+1] = 1'b1;
            exp_berr[T+busy+1] = tmo;
            exp_ld[T+busy+1]   = (tmo || wr) ? 64'd0 : model_load(f3, a, rdat);
            for (int k = 1; k <= busy; k++) begin
                @(posedge clk); #1;
                dmem_ready = !tmo && (k == busy);
                dmem_rdata = (k == busy) ? rdat : ~rdat;
            end
            @(posedge clk); #1;
            dmem_ready = 1'b0;
            valid_in   = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
        $fatal(1);
    end

    initial begin
        int t, r0, v0;
        reset = 1'b1; valid_in = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        funct3 = 3'd0; addr = '0; wdata = '0; dmem_ready = 1'b0; dmem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_load_data", load_data, 64'd0);
        check("reset_wstrb", 64'(dmem_wstrb), 64'd0);
        check("reset_we", 64'(dmem_we), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // LB / LBU with byte3 = 0x80
        run_op(1'b1, 1'b0, 3'b000, 64'h1003, 64'd0, 64'h0000_0000_8000_0000, 1, t);
        check("lb_data", last_ld, 64'hFFFF_FFFF_FFFF_FF80);
        check("lb_latency", 64'(last_vout_cyc - t), 64'd2);
        check("lb_wstrb", 64'(last_wstrb), 64'd0);
        run_op(1'b1, 1'b0, 3'b100, 64'h1003, 64'd0, 64'h0000_0000_8000_0000, 1, t);
        check("lbu_data", last_ld, 64'h80);

        // SH to lane 6
        run_op(1'b0, 1'b1, 3'b001, 64'h2006, 64'hABCD, 64'd0, 1, t);
        check("sh_addr", last_addr, 64'h2000);
        check("sh_wstrb", 64'(last_wstrb), 64'hC0);
        check("sh_wdata_hi", 64'(last_wdata[63:48]), 64'hABCD);
        check("sh_we", 64'(last_we), 64'd1);

        // Misaligned LW: no request, result next cycle
        r0 = req_total;
        run_op(1'b1, 1'b0, 3'b010, 64'h3002, 64'd0, 64'd0, 1, t);
        check("lw_mis_noreq", 64'(req_total - r0), 64'd0);
        check("lw_mis_latency", 64'(last_vout_cyc - t), 64'd1);
        check("lw_mis_flag", 64'(last_mis), 64'd1);

        // LD with ready in the 5th BUSY cycle
        r0 = req_total;
        run_op(1'b1, 1'b0, 3'b011, 64'h4008, 64'd0, 64'h8123_4567_89AB_CDEF, 5, t);
        check("ld_req_cycles", 64'(req_total - r0), 64'd5);
        check("ld_latency", 64'(last_vout_cyc - t), 64'd6);
        check("ld_data", last_ld, 64'h8123_4567_89AB_CDEF);

        // Reset in 2nd BUSY cycle, late ready must be ignored
        v0 = vout_total;
        t = cyc;
        valid_in = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b011; addr = 64'h4800;
        exp_stall[t] = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            exp_stall[t+k] = 1'b1; exp_req[t+k] = 1'b1; exp_we[t+k] = 1'b0;
            exp_addr[t+k] = 64'h4800; exp_wstrb[t+k] = 8'h00;
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1; valid_in = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0; dmem_ready = 1'b1; dmem_rdata = 64'h1234;
        @(posedge clk); #1;
        dmem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy_no_vout", 64'(vout_total - v0), 64'd0);
        check("rst_busy_req", 64'(dmem_req), 64'd0);

        // Non-memory instruction
        run_op(1'b0, 1'b0, 3'b011, 64'h5555, 64'd0, 64'd0, 1, t);
        check("nonmem_latency", 64'(last_vout_cyc - t), 64'd1);
        check("nonmem_data", last_ld, 64'd0);

        // Assorted sizes, signs and lanes
        run_op(1'b1, 1'b0, 3'b001, 64'h5002, 64'd0, 64'h0000_0000_8001_0000, 1, t);
        check("lh_data", last_ld, 64'hFFFF_FFFF_FFFF_8001);
        run_op(1'b1, 1'b0, 3'b110, 64'h6004, 64'd0, 64'hF000_0001_0000_0000, 2, t);
        check("lwu_data", last_ld, 64'h0000_0000_F000_0001);
        run_op(1'b1, 1'b0, 3'b010, 64'h6004, 64'd0, 64'hF000_0001_0000_0000, 1, t);
        run_op(1'b1, 1'b0, 3'b111, 64'h6008, 64'd0, 64'hFEDC_BA98_7654_3210, 3, t);
        check("ld_zext_ignored", last_ld, 64'hFEDC_BA98_7654_3210);
        run_op(1'b0, 1'b1, 3'b000, 64'h7005, 64'h5A, 64'd0, 1, t);
        check("sb_wstrb", 64'(last_wstrb), 64'h20);
        run_op(1'b1, 1'b1, 3'b010, 64'h7004, 64'hDEAD_BEEF, 64'hFFFF_FFFF_FFFF_FFFF, 1, t);
        check("rdwr_store_wins", 64'(last_we), 64'd1);
        check("store_load_data", last_ld, 64'd0);
        run_op(1'b0, 1'b1, 3'b011, 64'h7008, 64'h0102_0304_0506_0708, 64'd0, 2, t);
        run_op(1'b0, 1'b1, 3'b011, 64'h8004, 64'h1, 64'd0, 1, t);
        run_op(1'b1, 1'b0, 3'b001, 64'h9001, 64'd0, 64'd0, 1, t);

        // Long wait: aborts with bus_error when the timeout is built in
        r0 = req_total;
`ifdef MEM_TIMEOUT_EN
        run_op(1'b1, 1'b0, 3'b011, 64'hA000, 64'd0, 64'h77, 0, t);
        check("tmo_req_cycles", 64'(req_total - r0), 64'd4);
        check("tmo_latency", 64'(last_vout_cyc - t), 64'd5);
        check("tmo_bus_error", 64'(last_berr), 64'd1);
        check("tmo_data", last_ld, 64'd0);
`else
        run_op(1'b1, 1'b0, 3'b011, 64'hA000, 64'd0, 64'h77, 8, t);
        check("wait_req_cycles", 64'(req_total - r0), 64'd8);
        check("wait_latency", 64'(last_vout_cyc - t), 64'd9);
        check("wait_bus_error", 64'(last_berr), 64'd0);
        check("wait_data", last_ld, 64'h77);
`endif

        repeat (2) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
